div_controller: RTL and testbench

//  FSM that sequences the 16-bit shift/subtract restoring divider datapath.

---
 rtl/div_pkg.sv | 21 ++
 rtl/div_iter_counter.sv | 27 ++
 rtl/div_controller.sv | 126 ++++++++++++
 tb/tb_div_controller.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the restoring-divider controller: state encoding and default width.
// Optional divide-by-zero detection is enabled with the DIV_ZERO_DET_EN macro.
package div_pkg;

  localparam int DIV_NBIT = 16;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_TEST  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = S_IDLE,
    ST_LOAD  = S_LOAD,
    ST_SHIFT = S_SHIFT,
    ST_TEST  = S_TEST,
    ST_DONE  = S_DONE
  } state_e;

endpackage

// File: rtl/div_iter_counter.sv
// Iteration counter for the divider: synchronous clear, increment, and a
// terminal-count flag asserted while the count equals NBIT-1.
module div_iter_counter #(
  parameter int NBIT  = 16,
  parameter int CNT_W = $clog2(NBIT) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == CNT_W'(NBIT - 1));

endmodule

// File: rtl/div_controller.sv
// Sequencer for the 16-bit shift/subtract restoring divider datapath.
// Define DIV_ZERO_DET_EN to short-circuit B==0 requests straight to DONE with div_err.
//
// Requester handshake: start is a level request sampled only in IDLE; it is
// neither queued nor acknowledged elsewhere. busy covers LOAD..TEST, and done
// is a one-cycle pulse marking a valid result at the datapath.
module div_controller
  import div_pkg::*;
#(
  parameter int NBIT = DIV_NBIT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [NBIT-1:0]            B,
  input  logic                       sub_cout,
  output logic                       busy,
  output logic                       done,
  output logic                       div_err,
  output logic                       dp_clr,
  output logic                       AB_load_QR_clr,
  output logic                       A_sl,
  output logic                       R_sl,
  output logic                       R_load_Q_shiftIn,
  output logic                       Q_sl,
  output logic [2:0]                 dbg_state,
  output logic [$clog2(NBIT):0]      dbg_bit_cnt
);

  localparam int CNT_W = $clog2(NBIT) + 1;

  state_e state, state_nxt;
  logic   cnt_clr, cnt_inc, cnt_tc;
  logic   zero_err, zero_err_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      zero_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      zero_err <= zero_err_nxt;
    end
  end

  div_iter_counter #(
    .NBIT  (NBIT),
    .CNT_W (CNT_W)
  ) u_iter_counter (
    .clk   (clk),
    .rst_n (reset),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .cnt   (dbg_bit_cnt),
    .tc    (cnt_tc)
  );

`ifdef DIV_ZERO_DET_EN
  logic b_zero;
  assign b_zero = (B == '0);
`else
  logic unused_b;
  assign unused_b = ^B;
  logic b_zero;
  assign b_zero = 1'b0;
`endif

  always_comb begin
    state_nxt        = state;
    zero_err_nxt     = 1'b0;
    busy             = 1'b0;
    done             = 1'b0;
    dp_clr           = 1'b0;
    AB_load_QR_clr   = 1'b0;
    A_sl             = 1'b0;
    R_sl             = 1'b0;
    R_load_Q_shiftIn = 1'b0;
    Q_sl             = 1'b0;
    cnt_clr          = 1'b0;
    cnt_inc          = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          // A zero divisor skips the datapath entirely; the flag rides into DONE.
          if (b_zero) begin
            state_nxt    = ST_DONE;
            zero_err_nxt = 1'b1;
          end else begin
            state_nxt = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        busy           = 1'b1;
        dp_clr         = 1'b1;
        AB_load_QR_clr = 1'b1;
        cnt_clr        = 1'b1;
        state_nxt      = ST_SHIFT;
      end
      ST_SHIFT: begin
        busy      = 1'b1;
        A_sl      = 1'b1;
        R_sl      = 1'b1;
        state_nxt = ST_TEST;
      end
      ST_TEST: begin
        busy             = 1'b1;
        Q_sl             = 1'b1;
        R_load_Q_shiftIn = sub_cout;
        cnt_inc          = 1'b1;
        state_nxt        = cnt_tc ? ST_DONE : ST_SHIFT;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign div_err   = (state == ST_DONE) && zero_err;
  assign dbg_state = state;

endmodule

// File: tb/tb_div_controller.sv
// Directed bench for div_controller with a behavioural restoring-divider datapath
// driven by the controller strobes; follows DIV_ZERO_DET_EN for the B==0 case.
module tb_div_controller;
  import div_pkg::*;

  localparam int NBIT = 16;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            start = 1'b0;
  logic [NBIT-1:0] B = '0;
  logic            sub_cout;
  logic            busy, done, div_err, dp_clr, AB_load_QR_clr;
  logic            A_sl, R_sl, R_load_Q_shiftIn, Q_sl;
  logic [2:0]      dbg_state;
  logic [4:0]      dbg_bit_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // clock / reset
  always #5 clk = ~clk;

  div_controller #(.NBIT(NBIT)) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .B                (B),
    .sub_cout         (sub_cout),
    .busy             (busy),
    .done             (done),
    .div_err          (div_err),
    .dp_clr           (dp_clr),
    .AB_load_QR_clr   (AB_load_QR_clr),
    .A_sl             (A_sl),
    .R_sl             (R_sl),
    .R_load_Q_shiftIn (R_load_Q_shiftIn),
    .Q_sl             (Q_sl),
    .dbg_state        (dbg_state),
    .dbg_bit_cnt      (dbg_bit_cnt)
  );

  // behavioural datapath: A/B/R/Q registers steered only by the strobes
  logic [15:0] a_drv = '0;
  logic [15:0] m_a = '0;
  logic [15:0] m_b = '0;
  logic [15:0] m_q = '0;
  logic [16:0] m_r = '0;

  always @(posedge clk) begin
    if (AB_load_QR_clr) begin
      m_a <= a_drv;
      m_b <= B;
      m_r <= '0;
      m_q <= '0;
    end else begin
      if (A_sl) m_a <= {m_a[14:0], 1'b0};
      if (R_sl) m_r <= {m_r[15:0], m_a[15]};
      if (R_load_Q_shiftIn) m_r <= m_r - {1'b0, m_b};
      if (Q_sl) m_q <= {m_q[14:0], R_load_Q_shiftIn};
    end
  end

  assign sub_cout = (m_r >= {1'b0, m_b});

  // per-run observations
  int done_cnt, done_first, done_last, err_cnt, err_stray;
  int busy_cnt, busy_first, load_cnt, clr_cnt, asl_cnt, rsl_cnt, qsl_cnt, rl_cnt, conflict_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // drive one request; observe n_cyc cycles after the accepting edge
  task automatic run_div(input logic [15:0] a, input logic [15:0] b, input int n_cyc,
                         input int pulse_cyc, input bit hold, input int abort_cyc);
    done_cnt = 0; done_first = 0; done_last = 0; err_cnt = 0; err_stray = 0;
    busy_cnt = 0; busy_first = 0; load_cnt = 0; clr_cnt = 0; asl_cnt = 0;
    rsl_cnt = 0; qsl_cnt = 0; rl_cnt = 0; conflict_cnt = 0;
    @(negedge clk);
    a_drv = a;
    B     = b;
    start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= n_cyc; c++) begin
      @(negedge clk);
      start = hold ? (c < 36) : (c == pulse_cyc);
      if (c == abort_cyc) begin
        reset = 1'b0;
        #1;
        check("abort_outputs", {busy, done, div_err, dp_clr, AB_load_QR_clr, A_sl, R_sl,
                                R_load_Q_shiftIn, Q_sl}, '0);
        check("abort_state", dbg_state, S_IDLE);
        check("abort_bit_cnt", dbg_bit_cnt, '0);
        start = 1'b0;
        return;
      end
      if (done) begin
        done_cnt++;
        if (done_first == 0) done_first = c;
        done_last = c;
        if (div_err) err_cnt++;
      end else if (div_err) begin
        err_stray++;
      end
      if (busy) begin
        busy_cnt++;
        if (busy_first == 0) busy_first = c;
      end
      if (AB_load_QR_clr) load_cnt++;
      if (dp_clr) clr_cnt++;
      if (A_sl) asl_cnt++;
      if (R_sl) rsl_cnt++;
      if (Q_sl) qsl_cnt++;
      if (R_load_Q_shiftIn) rl_cnt++;
      if (AB_load_QR_clr && (A_sl || R_sl || Q_sl)) conflict_cnt++;
    end
    start = 1'b0;
  endtask

  initial begin
    // reset state
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {busy, done, div_err, dp_clr, AB_load_QR_clr, A_sl, R_sl,
                            R_load_Q_shiftIn, Q_sl}, '0);
    check("reset_state", dbg_state, S_IDLE);
    check("reset_bit_cnt", dbg_bit_cnt, '0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // 100 / 7
    run_div(16'd100, 16'd7, 40, 0, 1'b0, 0);
    check("t1_done_cycle", done_first, 34);
    check("t1_done_count", done_cnt, 1);
    check("t1_q", m_q, 16'd14);
    check("t1_r", m_r[15:0], 16'd2);
    check("t1_busy_cycles", busy_cnt, 33);
    check("t1_busy_first", busy_first, 1);
    check("t1_div_err", err_cnt + err_stray, 0);
    check("t1_conflict", conflict_cnt, 0);

    // 65535 / 1
    run_div(16'hFFFF, 16'd1, 40, 0, 1'b0, 0);
    check("t2_q", m_q, 16'hFFFF);
    check("t2_r", m_r[15:0], 16'd0);
    check("t2_a_sl", asl_cnt, 16);
    check("t2_r_sl", rsl_cnt, 16);
    check("t2_q_sl", qsl_cnt, 16);
    check("t2_load", load_cnt, 1);
    check("t2_dp_clr", clr_cnt, 1);
    check("t2_r_load", rl_cnt, 16);

    // 5 / 9
    run_div(16'd5, 16'd9, 40, 0, 1'b0, 0);
    check("t3_q", m_q, 16'd0);
    check("t3_r", m_r[15:0], 16'd5);
    check("t3_r_load", rl_cnt, 0);
    check("t3_done_cycle", done_first, 34);

    // start pulse mid-divide is ignored
    run_div(16'd100, 16'd7, 40, 10, 1'b0, 0);
    check("t4_done_count", done_cnt, 1);
    check("t4_done_cycle", done_first, 34);
    check("t4_load", load_cnt, 1);

    // start held high re-triggers after DONE
    run_div(16'd100, 16'd7, 72, 0, 1'b1, 0);
    check("t4h_done_count", done_cnt, 2);
    check("t4h_done_first", done_first, 34);
    check("t4h_done_last", done_last, 69);
    check("t4h_busy_cycles", busy_cnt, 66);
    check("t4h_load", load_cnt, 2);
    check("t4h_q", m_q, 16'd14);
    check("t4h_r", m_r[15:0], 16'd2);

    // reset mid-divide, then a clean divide
    run_div(16'd1234, 16'd3, 40, 0, 1'b0, 12);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_div(16'd100, 16'd7, 40, 0, 1'b0, 0);
    check("t5_done_cycle", done_first, 34);
    check("t5_q", m_q, 16'd14);
    check("t5_r", m_r[15:0], 16'd2);

    // divide by zero
`ifdef DIV_ZERO_DET_EN
    run_div(16'd100, 16'd0, 10, 0, 1'b0, 0);
    check("t6_done_cycle", done_first, 1);
    check("t6_done_count", done_cnt, 1);
    check("t6_div_err", err_cnt, 1);
    check("t6_err_stray", err_stray, 0);
    check("t6_strobes", load_cnt + clr_cnt + asl_cnt + rsl_cnt + qsl_cnt + rl_cnt, 0);
    check("t6_busy", busy_cnt, 0);
`else
    run_div(16'd100, 16'd0, 40, 0, 1'b0, 0);
    check("t6_done_cycle", done_first, 34);
    check("t6_q", m_q, 16'hFFFF);
    check("t6_r", m_r[15:0], 16'd100);
    check("t6_div_err", err_cnt + err_stray, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
